// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the restoring divide sequencer.
// Holds the FSM state encoding and the default operand width.
// Imported by the interface, the step datapath and the sequencer top.
package div_pkg;

  // Byte form (AX / r8); 16 selects the word form (DX:AX / r16).
  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_CORR = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// ALU-control <-> divider bundle: operands and start request in,
// status, results and debug step counter out.
// master = ALU control unit, slave = div_sequencer.
interface div_sequencer_if import div_pkg::*; #(
  parameter int DW = DW_DEFAULT
);

  logic                 START;
  logic                 SIGNED;
  logic [2*DW-1:0]      DIVIDEND;
  logic [DW-1:0]        DIVISOR;
  logic                 BUSY;
  logic                 DONE;
  logic                 DIVZ;
  logic [DW-1:0]        QUO;
  logic [DW-1:0]        REM;
  logic [$clog2(DW):0]  STEP;

  modport master (
    output START, SIGNED, DIVIDEND, DIVISOR,
    input  BUSY, DONE, DIVZ, QUO, REM, STEP
  );

  modport slave (
    input  START, SIGNED, DIVIDEND, DIVISOR,
    output BUSY, DONE, DIVZ, QUO, REM, STEP
  );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
// Purely combinational, zero latency; no handshake.
// Caller guarantees prem < dvs, so the new remainder always fits DW bits.
module div_restore_step import div_pkg::*; #(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] prem,
  input  logic          din,
  input  logic [DW-1:0] dvs,
  output logic [DW-1:0] prem_nxt,
  output logic          qbit
);

  logic [DW:0] shifted;

  // Trial subtract; the low DW bits of the difference are exact even
  // though the shifted value is one bit wider than the result.
  always_comb begin
    shifted  = {prem, din};
    qbit     = (shifted >= {1'b0, dvs});
    prem_nxt = shifted[DW-1:0] - (qbit ? dvs : {DW{1'b0}});
  end

endmodule

// File: rtl/div_sequencer.sv
// DIV/IDIV sequencer: one quotient bit per falling edge, sign fix-up, divide-error detect.
// Latency DW+2 cycles from START (1 cycle on zero divisor / unsigned overflow).
// START honoured only in IDLE and never queued; DONE is a one-cycle strobe.
module div_sequencer import div_pkg::*; #(
  parameter int DW = DW_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST,
  div_sequencer_if.slave bus
);

  localparam int SW = $clog2(DW) + 1;

  state_t          state, state_nxt;
  logic [SW-1:0]   step;
  logic [DW-1:0]   prem, lo, dvs, qacc;
  logic            q_neg, r_neg, sgn, divz_r;
  logic [DW-1:0]   quo_r, rem_r;

  logic            dd_neg, dv_neg, early_err, ovf, qbit;
  logic [2*DW-1:0] dd_mag;
  logic [DW-1:0]   dv_mag, prem_nxt, q_fin, r_fin;

  div_restore_step #(.DW(DW)) u_step (
    .prem     (prem),
    .din      (lo[DW-1]),
    .dvs      (dvs),
    .prem_nxt (prem_nxt),
    .qbit     (qbit)
  );

  // Operand magnitudes, early error check and sign-corrected results.
  always_comb begin
    dd_neg    = bus.SIGNED & bus.DIVIDEND[2*DW-1];
    dv_neg    = bus.SIGNED & bus.DIVISOR[DW-1];
    dd_mag    = dd_neg ? -bus.DIVIDEND : bus.DIVIDEND;
    dv_mag    = dv_neg ? -bus.DIVISOR : bus.DIVISOR;
    // A high half >= divisor would need more than DW quotient bits.
    early_err = (dv_mag == '0) || (dd_mag[2*DW-1:DW] >= dv_mag);
    q_fin     = q_neg ? -qacc : qacc;
    r_fin     = r_neg ? -prem : prem;
    // Magnitude >= 2^(DW-1) overflows, including the representable -2^(DW-1).
    ovf       = sgn & qacc[DW-1];
  end

  // State register; all sequencing happens on the falling edge.
  always_ff @(negedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.START) state_nxt = early_err ? ST_DONE : ST_ITER;
      ST_ITER: if (step == SW'(DW - 1)) state_nxt = ST_CORR;
      ST_CORR: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(negedge CLK) begin
    if (RST) begin
      step   <= '0;
      prem   <= '0;
      lo     <= '0;
      dvs    <= '0;
      qacc   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      sgn    <= 1'b0;
      divz_r <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            prem   <= dd_mag[2*DW-1:DW];
            lo     <= dd_mag[DW-1:0];
            dvs    <= dv_mag;
            q_neg  <= dd_neg ^ dv_neg;
            r_neg  <= dd_neg;
            sgn    <= bus.SIGNED;
            step   <= '0;
            divz_r <= early_err;
          end
        end
        ST_ITER: begin
          prem <= prem_nxt;
          lo   <= {lo[DW-2:0], 1'b0};
          qacc <= {qacc[DW-2:0], qbit};
          step <= step + SW'(1);
        end
        ST_CORR: begin
          divz_r <= ovf;
          // Results become visible together with the DONE strobe.
          if (!ovf) begin
            quo_r <= q_fin;
            rem_r <= r_fin;
          end
        end
        default: divz_r <= 1'b0;
      endcase
    end
  end

  assign bus.BUSY = (state == ST_ITER) || (state == ST_CORR);
  assign bus.DONE = (state == ST_DONE);
  assign bus.DIVZ = (state == ST_DONE) & divz_r;
  assign bus.QUO  = quo_r;
  assign bus.REM  = rem_r;
  assign bus.STEP = step;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer (DW=8): unsigned/signed results,
// divide errors, latency, ignored START, back-to-back and mid-op reset.
// Inputs driven and outputs sampled on the rising edge, away from the active falling edge.
module tb_div_sequencer;
  import div_pkg::*;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   passes = 0;

  div_sequencer_if #(.DW(DW)) bus();

  div_sequencer #(.DW(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Present one operation for a single sampling edge; returns one cycle after e0.
  task automatic start_op(input logic s, input logic [15:0] dd, input logic [7:0] dv);
    @(posedge CLK);
    bus.SIGNED   = s;
    bus.DIVIDEND = dd;
    bus.DIVISOR  = dv;
    bus.START    = 1'b1;
    @(posedge CLK);
    bus.START    = 1'b0;
  endtask

  // Bounded wait for DONE; cyc is the START-to-DONE latency in cycles.
  task automatic wait_done(output int cyc, output int busy_n, output logic dz, output logic stray);
    cyc = 1; busy_n = 0; stray = 1'b0;
    while (bus.DONE !== 1'b1 && cyc < 40) begin
      if (bus.BUSY === 1'b1) busy_n++;
      if (bus.DIVZ !== 1'b0) stray = 1'b1;
      @(posedge CLK);
      cyc++;
    end
    dz = bus.DIVZ;
  endtask

  // Count DONE strobes over n cycles.
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      if (bus.DONE === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.START = 1'b0; bus.SIGNED = 1'b0; bus.DIVIDEND = '0; bus.DIVISOR = '0;
    repeat (3) @(posedge CLK);
    checks++; if ({bus.BUSY, bus.DONE, bus.DIVZ} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {bus.BUSY, bus.DONE, bus.DIVZ}); else passes++;
    checks++; if ({bus.QUO, bus.REM} !== 16'h0000) $display("FAIL reset_quo_rem: got %h want 0000", {bus.QUO, bus.REM}); else passes++;
    checks++; if (bus.STEP !== 4'd0) $display("FAIL reset_step: got %0d want 0", bus.STEP); else passes++;
    RST = 1'b0;
  endtask

  task automatic test_unsigned();
    int cyc, busy_n; logic dz, stray;
    start_op(1'b0, 16'h0064, 8'h07);
    wait_done(cyc, busy_n, dz, stray);
    checks++; if (cyc !== 10) $display("FAIL unsigned_latency: got %0d want 10", cyc); else passes++;
    checks++; if (busy_n !== 9) $display("FAIL unsigned_busy_cycles: got %0d want 9", busy_n); else passes++;
    checks++; if (dz !== 1'b0 || stray !== 1'b0) $display("FAIL unsigned_divz: got %b/%b want 0/0", dz, stray); else passes++;
    @(posedge CLK);
    checks++; if (bus.DONE !== 1'b0) $display("FAIL unsigned_done_pulse: got %b want 0", bus.DONE); else passes++;
    checks++; if ({bus.QUO, bus.REM} !== 16'h0E02) $display("FAIL unsigned_result: got %h want 0e02", {bus.QUO, bus.REM}); else passes++;
  endtask

  task automatic test_early_errors();
    int cyc, busy_n; logic dz, stray;
    // zero divisor
    start_op(1'b0, 16'h0064, 8'h00);
    wait_done(cyc, busy_n, dz, stray);
    checks++; if (cyc !== 1 || dz !== 1'b1) $display("FAIL divzero_done: got lat %0d divz %b want 1/1", cyc, dz); else passes++;
    @(posedge CLK);
    checks++; if ({bus.DONE, bus.DIVZ} !== 2'b00) $display("FAIL divzero_after: got %b want 00", {bus.DONE, bus.DIVZ}); else passes++;
    checks++; if ({bus.QUO, bus.REM} !== 16'h0E02) $display("FAIL divzero_hold: got %h want 0e02", {bus.QUO, bus.REM}); else passes++;
    // unsigned overflow: high half equals divisor
    start_op(1'b0, 16'h0700, 8'h07);
    wait_done(cyc, busy_n, dz, stray);
    checks++; if (cyc !== 1 || dz !== 1'b1) $display("FAIL uovf_done: got lat %0d divz %b want 1/1", cyc, dz); else passes++;
    @(posedge CLK);
    checks++; if ({bus.QUO, bus.REM} !== 16'h0E02) $display("FAIL uovf_hold: got %h want 0e02", {bus.QUO, bus.REM}); else passes++;
  endtask

  // Two signed divides, the second started in the IDLE cycle right after DONE.
  task automatic test_back_to_back();
    int cyc, busy_n; logic dz, stray;
    start_op(1'b1, 16'hFF9C, 8'h07);
    wait_done(cyc, busy_n, dz, stray);
    checks++; if (cyc !== 10 || dz !== 1'b0) $display("FAIL signed1_done: got lat %0d divz %b want 10/0", cyc, dz); else passes++;
    @(posedge CLK);
    checks++; if ({bus.QUO, bus.REM} !== 16'hF2FE) $display("FAIL signed1_result: got %h want f2fe", {bus.QUO, bus.REM}); else passes++;
    bus.SIGNED = 1'b1; bus.DIVIDEND = 16'h0064; bus.DIVISOR = 8'hF9; bus.START = 1'b1;
    @(posedge CLK);
    bus.START = 1'b0;
    wait_done(cyc, busy_n, dz, stray);
    checks++; if (cyc !== 10 || dz !== 1'b0) $display("FAIL signed2_done: got lat %0d divz %b want 10/0", cyc, dz); else passes++;
    @(posedge CLK);
    checks++; if ({bus.QUO, bus.REM} !== 16'hF202) $display("FAIL signed2_result: got %h want f202", {bus.QUO, bus.REM}); else passes++;
  endtask

  task automatic test_signed_overflow();
    int cyc, busy_n; logic dz, stray;
    start_op(1'b1, 16'hFF80, 8'h01);
    wait_done(cyc, busy_n, dz, stray);
    checks++; if (cyc !== 10 || dz !== 1'b1) $display("FAIL sovf_done: got lat %0d divz %b want 10/1", cyc, dz); else passes++;
    checks++; if (stray !== 1'b0) $display("FAIL sovf_divz_early: got %b want 0", stray); else passes++;
    @(posedge CLK);
    checks++; if ({bus.QUO, bus.REM} !== 16'hF202) $display("FAIL sovf_hold: got %h want f202", {bus.QUO, bus.REM}); else passes++;
  endtask

  task automatic test_start_ignored();
    int cyc, busy_n, cnt; logic dz, stray;
    start_op(1'b0, 16'h0064, 8'h07);
    repeat (3) @(posedge CLK);
    bus.DIVIDEND = 16'h00FF; bus.DIVISOR = 8'h10; bus.START = 1'b1;
    @(posedge CLK);
    bus.START = 1'b0;
    wait_done(cyc, busy_n, dz, stray);
    checks++; if (cyc !== 6 || dz !== 1'b0) $display("FAIL ignore_iter_done: got lat %0d divz %b want 6/0", cyc, dz); else passes++;
    bus.START = 1'b1;
    @(posedge CLK);
    bus.START = 1'b0;
    checks++; if ({bus.QUO, bus.REM} !== 16'h0E02) $display("FAIL ignore_result: got %h want 0e02", {bus.QUO, bus.REM}); else passes++;
    count_done(15, cnt);
    checks++; if (cnt !== 0 || bus.BUSY !== 1'b0) $display("FAIL ignore_extra_done: got %0d dones busy %b want 0/0", cnt, bus.BUSY); else passes++;
  endtask

  task automatic test_reset_mid();
    int cyc, busy_n, cnt, guard; logic dz, stray;
    start_op(1'b0, 16'h0064, 8'h07);
    guard = 0;
    while (bus.STEP !== 4'd4 && guard < 20) begin
      @(posedge CLK);
      guard++;
    end
    checks++; if (bus.STEP !== 4'd4) $display("FAIL rst_reach_step4: got %0d want 4", bus.STEP); else passes++;
    RST = 1'b1;
    @(posedge CLK);
    RST = 1'b0;
    checks++; if ({bus.BUSY, bus.DONE, bus.DIVZ, bus.STEP} !== 7'd0) $display("FAIL rst_mid_state: got %b want 0000000", {bus.BUSY, bus.DONE, bus.DIVZ, bus.STEP}); else passes++;
    checks++; if ({bus.QUO, bus.REM} !== 16'h0000) $display("FAIL rst_mid_outputs: got %h want 0000", {bus.QUO, bus.REM}); else passes++;
    count_done(14, cnt);
    checks++; if (cnt !== 0) $display("FAIL rst_mid_no_done: got %0d want 0", cnt); else passes++;
    start_op(1'b0, 16'h00FF, 8'h10);
    wait_done(cyc, busy_n, dz, stray);
    checks++; if (cyc !== 10 || dz !== 1'b0) $display("FAIL post_rst_done: got lat %0d divz %b want 10/0", cyc, dz); else passes++;
    @(posedge CLK);
    checks++; if ({bus.QUO, bus.REM} !== 16'h0F0F) $display("FAIL post_rst_result: got %h want 0f0f", {bus.QUO, bus.REM}); else passes++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_early_errors();
    test_back_to_back();
    test_signed_overflow();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle restoring divider with its own control FSM for the 8088 ALU, executing DIV/IDIV (byte form by default: AX / r8 → AL quotient, AH remainder). It sequences one quotient bit per clock, applies sign correction, and detects divide errors (zero divisor, quotient overflow) that the ALU raises as interrupt type 0. It sits beside the ALU datapath, started by the ALU control unit and handing results back with a one-cycle DONE strobe.

## Interface
- DW, 8, divisor/quotient/remainder width; dividend is 2*DW. 16 gives the word form (DX:AX / r16).

- CLK  in  1  clock; all state changes on the falling edge, matching the ALU sequencers
- RST  in  1  reset; synchronous, active-high
- START  in  1  request; sampled only in IDLE
- SIGNED  in  1  1 = IDIV, 0 = DIV; captured with START
- DIVIDEND  in  2*DW  dividend; captured with START
- DIVISOR  in  DW  divisor; captured with START
- BUSY  out  1  high in ITER and CORR
- DONE  out  1  one-cycle completion pulse
- DIVZ  out  1  divide error, valid while DONE=1
- QUO  out  DW  quotient register
- REM  out  DW  remainder register
- STEP  out  clog2(DW)+1  iteration counter, for debug and bench observation

## Operation
- States: IDLE, ITER, CORR, DONE.
- IDLE, START=1:
  - Latch the operand magnitudes (two's-complement absolute values when SIGNED=1).
  - Latch the result signs: quotient negative if the operand signs differ; remainder takes the dividend's sign.
  - Clear STEP.
- Early error check in IDLE, in priority order:
  - Divisor magnitude = 0 → DONE with DIVZ=1.
  - High half of dividend magnitude ≥ divisor magnitude → DONE with DIVZ=1.
  - Otherwise → ITER.
- ITER, one restoring step per edge:
  - Shift partial remainder left, bringing in the next dividend bit, MSB first.
  - Trial-subtract the divisor. If non-negative, keep the difference and set quotient bit = 1; otherwise restore and set quotient bit = 0.
  - Increment STEP. After step DW (STEP = DW) → CORR.
- CORR:
  - Negate quotient and/or remainder per the latched signs.
  - Signed overflow: if SIGNED and quotient magnitude ≥ 2^(DW-1), then DIVZ=1. The quotient -2^(DW-1) is also an error, matching the 8088.
  - → DONE.
- DONE:
  - DONE=1 for exactly one cycle, then → IDLE.
  - DIVZ=0: QUO/REM load the new result.
  - DIVZ=1: QUO/REM keep their previous values.
- QUO/REM hold until the next successful completion.
- START is ignored in ITER, CORR and DONE. It is never queued.

## Timing
- Reset values: state IDLE; DONE, DIVZ, BUSY = 0; QUO, REM, STEP = 0.
- START sampled at edge e0:
  - Normal or signed-overflow case: ITER covers edges e1..eDW, CORR is at e(DW+1), DONE is high in the cycle after e(DW+1). Latency is DW+2 cycles (10 for DW=8).
  - Early error: DONE with DIVZ=1 is high in the cycle after e0 (latency 1).
- DIVZ is high only alongside DONE; it is 0 in all other cycles.
- Back-to-back operation: a START in the cycle after DONE (state IDLE) is accepted.
- RST during any state returns to IDLE at that edge with reset values. No DONE is produced for the aborted operation.

## Structure
- Shared package div_pkg:
  - state encoding constants (2-bit: IDLE=00, ITER=01, CORR=10, DONE=11)
  - default DW
- Sub-module div_restore_step (combinational):
  - inputs: partial remainder, next dividend bit, divisor
  - outputs: new partial remainder, quotient bit
- The FSM, counter, sign logic and output registers stay in div_sequencer.

## Test plan
- Unsigned 0x0064 / 0x07 → QUO=0x0E, REM=0x02, DIVZ=0, DONE exactly 10 cycles after START, BUSY high for 9 cycles (e1..e(DW+1)).
- DIVISOR=0x00, and separately 0x0700 / 0x07 (unsigned overflow) → DONE the next cycle with DIVZ=1, QUO/REM unchanged.
- Signed 0xFF9C / 0x07 → QUO=0xF2, REM=0xFE. Signed 0x0064 / 0xF9 → QUO=0xF2, REM=0x02.
- Signed 0xFF80 / 0x01 → passes the early check, DIVZ=1 at DONE after 10 cycles, QUO/REM unchanged.
- START pulsed during ITER and during DONE → ignored: a single DONE, result of the first operation only.
- RST asserted at STEP=4 → IDLE and zeroed outputs next cycle, no DONE. A following 0x00FF / 0x10 → QUO=0x0F, REM=0x0F.
